// File: rtl/aes_ahb_job_sequencer.sv
// AHB-Lite manager that loads an AES key and plaintext into a memory-mapped AES core,
// starts it and reads the ciphertext back as 13 non-pipelined SINGLE transfers.
module aes_ahb_job_sequencer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic         hclk,
   input  logic         hrstn,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [127:0] job_key,
   input  logic [127:0] job_ptext,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_data,
   output logic         res_err,
   output logic [3:0]   res_err_idx,
   output logic [31:0]  haddr,
   output logic [1:0]   htrans,
   output logic         hwrite,
   output logic [2:0]   hsize,
   output logic [2:0]   hburst,
   output logic [31:0]  hwdata,
   input  logic         hready,
   input  logic [31:0]  hrdata,
   input  logic         hresp
);

   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERRW, ST_RESP} state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [3:0] START_IDX     = 4'd8;
   localparam logic [3:0] LAST_IDX      = 4'd12;

   state_e         state_q, state_d;
   logic [3:0]     idx_q, idx_d;
   logic [127:0]   key_q, key_d;
   logic [127:0]   ptext_q, ptext_d;
   logic           job_ready_q, job_ready_d;
   logic           res_valid_q, res_valid_d;
   logic [127:0]   res_data_q, res_data_d;
   logic           res_err_q, res_err_d;
   logic [3:0]     res_err_idx_q, res_err_idx_d;
   logic [31:0]    haddr_q, haddr_d;
   logic [1:0]     htrans_q, htrans_d;
   logic           hwrite_q, hwrite_d;
   logic [31:0]    hwdata_q, hwdata_d;
   logic [3:0]     next_idx;
   logic [1:0]     rd_word;

   // Register map: key 0x00-0x0C, ptext 0x10-0x1C, start 0x2C, ciphertext 0x30-0x3C.
   function automatic logic [31:0] xfer_addr(input logic [3:0] idx);
      logic [31:0] off;
      off = {26'd0, idx, 2'b00};
      if (idx == START_IDX)
         off = 32'h0000_002C;
      else if (idx > START_IDX)
         off = off + 32'h0000_000C;
      return BASE_ADDR + off;
   endfunction

   function automatic logic [31:0] xfer_wdata(input logic [3:0]   idx,
                                              input logic [127:0] key,
                                              input logic [127:0] ptext);
      logic [31:0] wd;
      if (idx < 4'd4)
         wd = key[{idx[1:0], 5'd0} +: 32];
      else if (idx < START_IDX)
         wd = ptext[{idx[1:0], 5'd0} +: 32];
      else if (idx == START_IDX)
         wd = 32'h0000_0001;
      else
         wd = 32'h0000_0000;
      return wd;
   endfunction

   always_comb begin
      // NOTE: every _d starts from its _q so no path through the case leaves a signal unassigned, which would infer a latch.
      state_d       = state_q;
      idx_d         = idx_q;
      key_d         = key_q;
      ptext_d       = ptext_q;
      job_ready_d   = job_ready_q;
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_err_d     = res_err_q;
      res_err_idx_d = res_err_idx_q;
      haddr_d       = haddr_q;
      htrans_d      = htrans_q;
      hwrite_d      = hwrite_q;
      hwdata_d      = hwdata_q;
      next_idx      = idx_q + 4'd1;
      rd_word       = idx_q[1:0] - 2'd1;

      case (state_q)
         ST_IDLE: begin
            job_ready_d = 1'b1;
            if (job_valid && job_ready_q) begin
               key_d         = job_key;
               ptext_d       = job_ptext;
               idx_d         = 4'd0;
               res_err_d     = 1'b0;
               res_err_idx_d = 4'd0;
               res_data_d    = '0;
               job_ready_d   = 1'b0;
               haddr_d       = xfer_addr(4'd0);
               hwrite_d      = 1'b1;
               htrans_d      = HTRANS_NONSEQ;
               state_d       = ST_ADDR;
            end
         end

         ST_ADDR: begin
            htrans_d = HTRANS_IDLE;
            hwdata_d = xfer_wdata(idx_q, key_q, ptext_q);
            state_d  = ST_DATA;
         end

         ST_DATA: begin
            if (hresp) begin
               res_err_d     = 1'b1;
               res_err_idx_d = idx_q;
               hwdata_d      = '0;
               if (hready) begin
                  res_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end else begin
                  state_d = ST_ERRW;
               end
            end else if (hready) begin
               hwdata_d = '0;
               if (!hwrite_q)
                  res_data_d[{rd_word, 5'd0} +: 32] = hrdata;
               if (idx_q == LAST_IDX) begin
                  res_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end else begin
                  idx_d    = next_idx;
                  haddr_d  = xfer_addr(next_idx);
                  hwrite_d = (next_idx <= START_IDX);
                  htrans_d = HTRANS_NONSEQ;
                  state_d  = ST_ADDR;
               end
            end
         end

         // Second cycle of a two-cycle ERROR response: nothing new is issued.
         ST_ERRW: begin
            if (hready) begin
               res_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end

         ST_RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               job_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
   always_ff @(posedge hclk) begin
      if (!hrstn) begin
         state_q       <= ST_IDLE;
         idx_q         <= 4'd0;
         job_ready_q   <= 1'b1;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_err_q     <= 1'b0;
         res_err_idx_q <= 4'd0;
         haddr_q       <= '0;
         htrans_q      <= HTRANS_IDLE;
         hwrite_q      <= 1'b0;
         hwdata_q      <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         job_ready_q   <= job_ready_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_err_q     <= res_err_d;
         res_err_idx_q <= res_err_idx_d;
         haddr_q       <= haddr_d;
         htrans_q      <= htrans_d;
         hwrite_q      <= hwrite_d;
         hwdata_q      <= hwdata_d;
      end
   end

   // NOTE: job operand registers carry no reset; they are always loaded on accept before being read.
   always_ff @(posedge hclk) begin
      key_q   <= key_d;
      ptext_q <= ptext_d;
   end

   assign job_ready   = job_ready_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_err     = res_err_q;
   assign res_err_idx = res_err_idx_q;
   assign haddr       = haddr_q;
   assign htrans      = htrans_q;
   assign hwrite      = hwrite_q;
   assign hwdata      = hwdata_q;
   assign hsize       = 3'b010;
   assign hburst      = 3'b000;

endmodule

// File: tb/tb_aes_ahb_job_sequencer.sv
// Scoreboard bench: stimulus queues expected AHB transfers and results, monitors pop and compare
// as the sequencer presents them; a bench-side subordinate injects waits and ERROR responses.
module tb_aes_ahb_job_sequencer;

   localparam logic [31:0]  BASE  = 32'h4000_0000;
   localparam logic [127:0] K1    = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] P1    = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] K2    = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
   localparam logic [127:0] P2    = 128'h3243F6A8885A308D313198A2E0370734;
   localparam logic [127:0] RES_A = 128'h000000A3_000000A2_000000A1_000000A0;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct packed {
      logic [127:0] data;
      logic         err;
      logic [3:0]   eidx;
   } res_t;

   logic         hclk = 1'b0;
   logic         hrstn = 1'b0;
   logic         job_valid = 1'b0;
   logic         job_ready;
   logic [127:0] job_key = '0;
   logic [127:0] job_ptext = '0;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [127:0] res_data;
   logic         res_err;
   logic [3:0]   res_err_idx;
   logic [31:0]  haddr;
   logic [1:0]   htrans;
   logic         hwrite;
   logic [2:0]   hsize;
   logic [2:0]   hburst;
   logic [31:0]  hwdata;
   logic         hready = 1'b1;
   logic [31:0]  hrdata = '0;
   logic         hresp = 1'b0;

   // Subordinate behaviour knobs, written only by the stimulus process.
   logic [31:0]  stall_addr = 32'hFFFF_FFFF;
   int           stall_cycles = 0;
   logic [31:0]  err_addr = 32'hFFFF_FFFF;
   bit           err_en = 1'b0;
   bit           err_two = 1'b0;

   xfer_t exp_x[$];
   res_t  exp_r[$];
   int    n_total = 0;
   int    n_bad = 0;

   always #5 hclk = ~hclk;

   aes_ahb_job_sequencer #(.BASE_ADDR(BASE)) dut (
      .hclk        (hclk),
      .hrstn       (hrstn),
      .job_valid   (job_valid),
      .job_ready   (job_ready),
      .job_key     (job_key),
      .job_ptext   (job_ptext),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_err     (res_err),
      .res_err_idx (res_err_idx),
      .haddr       (haddr),
      .htrans      (htrans),
      .hwrite      (hwrite),
      .hsize       (hsize),
      .hburst      (hburst),
      .hwdata      (hwdata),
      .hready      (hready),
      .hrdata      (hrdata),
      .hresp       (hresp)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void push_xfers(input logic [127:0] key, input logic [127:0] pt, input int n);
      for (int i = 0; i < n; i++) begin
         xfer_t x;
         if (i < 4) begin
            x.addr = BASE + 32'(4 * i);
            x.write = 1'b1;
            x.wdata = key[32*i +: 32];
         end else if (i < 8) begin
            x.addr = BASE + 32'h10 + 32'(4 * (i - 4));
            x.write = 1'b1;
            x.wdata = pt[32*(i-4) +: 32];
         end else if (i == 8) begin
            x.addr = BASE + 32'h2C;
            x.write = 1'b1;
            x.wdata = 32'h1;
         end else begin
            x.addr = BASE + 32'h30 + 32'(4 * (i - 9));
            x.write = 1'b0;
            x.wdata = 32'h0;
         end
         exp_x.push_back(x);
      end
   endfunction

   function automatic void push_res(input logic [127:0] d, input logic e, input logic [3:0] ei);
      res_t r;
      r.data = d;
      r.err  = e;
      r.eidx = ei;
      exp_r.push_back(r);
   endfunction

   // Subordinate: responds during the data phase following each NONSEQ address phase.
   bit          sl_dp = 1'b0;
   bit          sl_err_phase = 1'b0;
   logic [31:0] sl_addr = '0;
   logic        sl_write = 1'b0;
   int          sl_wait = 0;

   always begin
      @(negedge hclk);
      #1;
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = 32'h5555_5555;
      if (!hrstn) begin
         sl_dp = 1'b0;
      end else begin
         if (sl_dp) begin
            if (err_en && sl_addr == err_addr) begin
               hrdata = 32'hDEAD_BEEF;
               hresp  = 1'b1;
               if (err_two && !sl_err_phase) begin
                  hready = 1'b0;
                  sl_err_phase = 1'b1;
               end else begin
                  sl_err_phase = 1'b0;
                  sl_dp = 1'b0;
               end
            end else if (sl_wait > 0) begin
               hready = 1'b0;
               sl_wait--;
            end else begin
               if (!sl_write)
                  hrdata = 32'hA0 + ((sl_addr - BASE - 32'h30) >> 2);
               sl_dp = 1'b0;
            end
         end
         if (htrans == 2'b10) begin
            sl_dp = 1'b1;
            sl_err_phase = 1'b0;
            sl_addr = haddr;
            sl_write = hwrite;
            sl_wait = (haddr == stall_addr) ? stall_cycles : 0;
         end
      end
   end

   // Transfer monitor.
   bit    mon_dp = 1'b0;
   bit    mon_first = 1'b0;
   xfer_t mon_x;

   always begin
      @(negedge hclk);
      #2;
      if (!hrstn) begin
         mon_dp = 1'b0;
      end else begin
         if (mon_dp) begin
            check("dp_haddr_hold", haddr, mon_x.addr);
            if (mon_first)
               check("dp_hwdata", hwdata, mon_x.wdata);
            mon_first = 1'b0;
            if (hready)
               mon_dp = 1'b0;
         end
         if (htrans == 2'b10) begin
            check("xfer_expected", exp_x.size() != 0, 1);
            if (exp_x.size() != 0) begin
               mon_x = exp_x.pop_front();
               check("ap_haddr", haddr, mon_x.addr);
               check("ap_hwrite", hwrite, mon_x.write);
               check("ap_hsize", hsize, 3'b010);
               check("ap_hburst", hburst, 3'b000);
               mon_dp = 1'b1;
               mon_first = 1'b1;
            end
         end else begin
            check("htrans_idle", htrans, 2'b00);
         end
      end
   end

   // Result monitor.
   res_t mon_r;

   always begin
      @(negedge hclk);
      #2;
      if (hrstn && res_valid && res_ready) begin
         check("res_expected", exp_r.size() != 0, 1);
         if (exp_r.size() != 0) begin
            mon_r = exp_r.pop_front();
            check("res_data", res_data, mon_r.data);
            check("res_err", res_err, mon_r.err);
            check("res_err_idx", res_err_idx, mon_r.eidx);
         end
      end
   end

   task automatic start_job(input logic [127:0] key, input logic [127:0] pt);
      int n;
      @(negedge hclk);
      job_key = key;
      job_ptext = pt;
      job_valid = 1'b1;
      n = 0;
      while (!job_ready && n < 200) begin
         @(negedge hclk);
         n++;
      end
      check("job_ready_before_accept", job_ready, 1);
      @(posedge hclk);
      #1;
      job_valid = 1'b0;
   endtask

   task automatic wait_valid(input int exp_lat, input string name);
      int lat;
      lat = 0;
      while (lat < 300) begin
         @(posedge hclk);
         #1;
         lat++;
         if (res_valid) break;
      end
      check(name, lat, exp_lat);
   endtask

   task automatic wait_handshake();
      int n;
      n = 0;
      while (res_valid && n < 50) begin
         @(posedge hclk);
         #1;
         n++;
      end
      check("res_handshake_done", res_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge hclk);
      check("rst_haddr", haddr, 0);
      check("rst_htrans", htrans, 0);
      check("rst_hwrite", hwrite, 0);
      check("rst_hwdata", hwdata, 0);
      check("rst_hsize", hsize, 3'b010);
      check("rst_hburst", hburst, 3'b000);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_err", res_err, 0);
      check("rst_res_err_idx", res_err_idx, 0);
      hrstn = 1'b1;
      @(posedge hclk);
      #1;
      check("rst_job_ready", job_ready, 1);

      // Zero-wait job.
      push_xfers(K1, P1, 13);
      push_res(RES_A, 1'b0, 4'd0);
      start_job(K1, P1);
      wait_valid(26, "lat_zero_wait");
      wait_handshake();

      // 40-cycle encryption stall after the start write.
      stall_addr = BASE + 32'h2C;
      stall_cycles = 40;
      push_xfers(K2, P2, 13);
      push_res(RES_A, 1'b0, 4'd0);
      start_job(K2, P2);
      wait_valid(66, "lat_stall40");
      wait_handshake();
      stall_cycles = 0;

      // Two-cycle ERROR on idx 5.
      err_en = 1'b1;
      err_two = 1'b1;
      err_addr = BASE + 32'h14;
      push_xfers(K1, P1, 6);
      push_res(128'h0, 1'b1, 4'd5);
      start_job(K1, P1);
      wait_valid(13, "lat_err_idx5");
      wait_handshake();

      // Single-cycle ERROR on idx 10: word 0 already read, others stay zero.
      err_two = 1'b0;
      err_addr = BASE + 32'h34;
      push_xfers(K2, P2, 11);
      push_res(128'h000000A0, 1'b1, 4'd10);
      start_job(K2, P2);
      wait_valid(22, "lat_err_idx10");
      wait_handshake();
      err_en = 1'b0;

      // Reset during the start-write data phase aborts the job.
      stall_cycles = 5;
      push_xfers(K1, P1, 9);
      start_job(K1, P1);
      n = 0;
      @(negedge hclk);
      while (!(htrans == 2'b00 && haddr == BASE + 32'h2C) && n < 100) begin
         @(negedge hclk);
         n++;
      end
      check("abort_reached_start_data", haddr, BASE + 32'h2C);
      hrstn = 1'b0;
      @(posedge hclk);
      #1;
      check("abort_htrans", htrans, 0);
      check("abort_res_valid", res_valid, 0);
      check("abort_haddr", haddr, 0);
      @(negedge hclk);
      hrstn = 1'b1;
      stall_cycles = 0;
      repeat (2) @(negedge hclk);
      check("abort_job_ready", job_ready, 1);
      check("abort_no_result", res_valid, 0);
      push_xfers(K2, P2, 13);
      push_res(RES_A, 1'b0, 4'd0);
      start_job(K2, P2);
      wait_valid(26, "lat_after_abort");
      wait_handshake();

      // Back-pressure on the result with a new job already waiting.
      @(negedge hclk);
      res_ready = 1'b0;
      push_xfers(K1, P1, 13);
      push_res(RES_A, 1'b0, 4'd0);
      start_job(K1, P1);
      wait_valid(26, "lat_backpressure");
      push_xfers(K2, P2, 13);
      push_res(RES_A, 1'b0, 4'd0);
      job_key = K2;
      job_ptext = P2;
      job_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge hclk);
         check("bp_res_valid", res_valid, 1);
         check("bp_res_data", res_data, RES_A);
         check("bp_job_ready", job_ready, 0);
         check("bp_htrans", htrans, 0);
      end
      res_ready = 1'b1;
      @(posedge hclk);
      #1;
      check("hs_res_valid", res_valid, 0);
      check("hs_job_ready", job_ready, 1);
      check("hs_no_accept_yet", htrans, 0);
      @(posedge hclk);
      #1;
      check("next_accept_htrans", htrans, 2'b10);
      check("next_accept_haddr", haddr, BASE);
      check("next_accept_job_ready", job_ready, 0);
      job_valid = 1'b0;
      wait_valid(26, "lat_back_to_back");
      wait_handshake();

      repeat (3) @(negedge hclk);
      check("xfer_queue_drained", exp_x.size(), 0);
      check("res_queue_drained", exp_r.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
